// File: rtl/spdif_receive.sv
// S/PDIF biphase-mark receiver: width-based pulse classifier, preamble/data FSM, stereo pair output.
// Defining SPDIF_RX_PARITY_CHECK_EN enables even-parity checking of slots 4..31.
module spdif_receive #(
   parameter int unsigned CLK_FREQ   = 98304000,
   parameter int unsigned SPDIF_BAUD = 3072000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spdif_in,
   output logic [31:0] data_left,
   output logic [31:0] data_right,
   output logic        valid,
   output logic        locked,
   output logic        parity_err
);
   localparam int unsigned UI   = CLK_FREQ / (2 * SPDIF_BAUD);
   localparam int unsigned TMAX = (7 * UI) / 2;
   localparam int unsigned CW   = $clog2(TMAX + 1);

   localparam logic [CW-1:0] WidS    = CW'(UI / 2);
   localparam logic [CW-1:0] WidM    = CW'((3 * UI) / 2);
   localparam logic [CW-1:0] WidL    = CW'((5 * UI) / 2);
   localparam logic [CW-1:0] WidTmax = CW'(TMAX);

   localparam logic [1:0] ClsBad = 2'd0;
   localparam logic [1:0] ClsS   = 2'd1;
   localparam logic [1:0] ClsM   = 2'd2;
   localparam logic [1:0] ClsL   = 2'd3;

   localparam logic [3:0] CodeB = 4'b0001;
   localparam logic [3:0] CodeM = 4'b0010;
   localparam logic [3:0] CodeW = 4'b0100;

   typedef enum logic [1:0] {StHunt, StPre, StData} state_e;

   logic [2:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   state_e        state_q, state_d;
   logic [1:0]    pre_q, pre_d, p1_q, p1_d, p2_q, p2_d;
   logic [4:0]    bit_q, bit_d;
   logic          half_q, half_d;
   logic [27:0]   sr_q, sr_d;
   logic [3:0]    kind_q, kind_d;
   logic          have_left_q, have_left_d, pair_bad_q, pair_bad_d;
   logic [31:0]   hold_q, hold_d, left_q, left_d, right_q, right_d;
   logic          valid_q, valid_d, locked_q, locked_d, perr_q, perr_d;

   logic          edge_det, timeout;
   logic [1:0]    cls;
   logic          bit_done, bit_val, par_fail;
   logic [27:0]   sr_shift;
   logic [31:0]   word;

   assign edge_det = sync_q[2] ^ sync_q[1];
   assign timeout  = !edge_det && (cnt_q == WidTmax - 1'b1);

   always_comb begin
      cnt_d = cnt_q;
      if (edge_det) begin
         cnt_d = CW'(1);
      end else if (cnt_q != WidTmax) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Width of the pulse that the current edge closes.
   always_comb begin
      if (cnt_q < WidS)         cls = ClsBad;
      else if (cnt_q < WidM)    cls = ClsS;
      else if (cnt_q < WidL)    cls = ClsM;
      else if (cnt_q < WidTmax) cls = ClsL;
      else                      cls = ClsBad;
   end

   always_comb begin
      state_d     = state_q;
      pre_d       = pre_q;
      p1_d        = p1_q;
      p2_d        = p2_q;
      bit_d       = bit_q;
      half_d      = half_q;
      sr_d        = sr_q;
      kind_d      = kind_q;
      have_left_d = have_left_q;
      pair_bad_d  = pair_bad_q;
      hold_d      = hold_q;
      left_d      = left_q;
      right_d     = right_q;
      valid_d     = 1'b0;
      locked_d    = locked_q;
      perr_d      = 1'b0;
      bit_done    = 1'b0;
      bit_val     = 1'b0;
      par_fail    = 1'b0;
      sr_shift    = sr_q;
      word        = '0;

      unique case (state_q)
         StHunt: begin
            if (edge_det && cls == ClsL) begin
               state_d = StPre;
               pre_d   = 2'd0;
            end
         end
         StPre: begin
            if (timeout || (edge_det && cls == ClsBad)) begin
               state_d = StHunt;
            end else if (edge_det) begin
               unique case (pre_q)
                  2'd0: begin
                     p1_d  = cls;
                     pre_d = 2'd1;
                  end
                  2'd1: begin
                     p2_d  = cls;
                     pre_d = 2'd2;
                  end
                  default: begin
                     state_d = StData;
                     bit_d   = 5'd0;
                     half_d  = 1'b0;
                     if ({p1_q, p2_q, cls} == {ClsS, ClsS, ClsL} && !have_left_q) begin
                        kind_d = CodeB;
                     end else if ({p1_q, p2_q, cls} == {ClsL, ClsS, ClsS} && !have_left_q) begin
                        kind_d = CodeM;
                     end else if ({p1_q, p2_q, cls} == {ClsM, ClsS, ClsM} && have_left_q) begin
                        kind_d = CodeW;
                     end else begin
                        state_d = StHunt;
                     end
                  end
               endcase
            end
         end
         StData: begin
            if (timeout) begin
               state_d = StHunt;
            end else if (edge_det) begin
               if (bit_q == 5'd28) begin
                  // Slot 31 is closed; only the first long pulse of a preamble may follow.
                  if (cls == ClsL) begin
                     state_d = StPre;
                     pre_d   = 2'd0;
                  end else begin
                     state_d = StHunt;
                  end
               end else if (cls == ClsS) begin
                  if (half_q) begin
                     bit_done = 1'b1;
                     bit_val  = 1'b1;
                     half_d   = 1'b0;
                  end else begin
                     half_d = 1'b1;
                  end
               end else if (cls == ClsM && !half_q) begin
                  bit_done = 1'b1;
               end else begin
                  state_d = StHunt;
               end
            end
         end
         default: state_d = StHunt;
      endcase

      if (bit_done) begin
         sr_shift = {bit_val, sr_q[27:1]};
         sr_d     = sr_shift;
         bit_d    = bit_q + 1'b1;
         if (bit_q == 5'd27) begin
`ifdef SPDIF_RX_PARITY_CHECK_EN
            par_fail = ^sr_shift;
`endif
            word   = {sr_shift, kind_q};
            perr_d = par_fail;
            if (kind_q == CodeW) begin
               if (!par_fail && !pair_bad_q) begin
                  left_d   = hold_q;
                  right_d  = word;
                  valid_d  = 1'b1;
                  locked_d = 1'b1;
               end
               have_left_d = 1'b0;
               pair_bad_d  = 1'b0;
            end else begin
               hold_d      = word;
               have_left_d = 1'b1;
               pair_bad_d  = par_fail;
            end
         end
      end

      if (state_d == StHunt && state_q != StHunt) begin
         locked_d    = 1'b0;
         have_left_d = 1'b0;
         pair_bad_d  = 1'b0;
         hold_d      = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q      <= '0;
         cnt_q       <= '0;
         state_q     <= StHunt;
         pre_q       <= '0;
         p1_q        <= '0;
         p2_q        <= '0;
         bit_q       <= '0;
         half_q      <= 1'b0;
         sr_q        <= '0;
         kind_q      <= '0;
         have_left_q <= 1'b0;
         pair_bad_q  <= 1'b0;
         hold_q      <= '0;
         left_q      <= '0;
         right_q     <= '0;
         valid_q     <= 1'b0;
         locked_q    <= 1'b0;
         perr_q      <= 1'b0;
      end else begin
         sync_q      <= {sync_q[1:0], spdif_in};
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         pre_q       <= pre_d;
         p1_q        <= p1_d;
         p2_q        <= p2_d;
         bit_q       <= bit_d;
         half_q      <= half_d;
         sr_q        <= sr_d;
         kind_q      <= kind_d;
         have_left_q <= have_left_d;
         pair_bad_q  <= pair_bad_d;
         hold_q      <= hold_d;
         left_q      <= left_d;
         right_q     <= right_d;
         valid_q     <= valid_d;
         locked_q    <= locked_d;
         perr_q      <= perr_d;
      end
   end

   assign data_left  = left_q;
   assign data_right = right_q;
   assign valid      = valid_q;
   assign locked     = locked_q;
   assign parity_err = perr_q;

endmodule

// File: tb/tb_spdif_receive.sv
// Directed bench for spdif_receive: BMC subframes built from pulse widths (UI = 16 clocks).
module tb_spdif_receive;
   localparam int UI = 16;
   localparam logic [3:0] PB = 4'b0001;
   localparam logic [3:0] PM = 4'b0010;
   localparam logic [3:0] PW = 4'b0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spdif_in = 1'b0;
   logic [31:0] data_left, data_right;
   logic        valid, locked, parity_err;

   int n_checks = 0;
   int n_fail = 0;
   int valid_cnt = 0;
   int perr_cnt = 0;
   int v0, p0;

   spdif_receive dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spdif_in   (spdif_in),
      .data_left  (data_left),
      .data_right (data_right),
      .valid      (valid),
      .locked     (locked),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (valid === 1'b1) valid_cnt++;
      if (parity_err === 1'b1) perr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Toggle the line, then hold it for n UI.
   task automatic pulse(input int n);
      spdif_in = ~spdif_in;
      repeat (n * UI) @(negedge clk);
   endtask

   task automatic send_sub(input logic [3:0] kind, input logic [27:0] slots, input int nbits);
      case (kind)
         PB:      begin pulse(3); pulse(1); pulse(1); pulse(3); end
         PM:      begin pulse(3); pulse(3); pulse(1); pulse(1); end
         default: begin pulse(3); pulse(2); pulse(1); pulse(2); end
      endcase
      for (int i = 0; i < nbits; i++) begin
         if (slots[i]) begin
            pulse(1);
            pulse(1);
         end else begin
            pulse(2);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // Reset state
      idle(3);
      check("rst_left", data_left, 32'h0);
      check("rst_right", data_right, 32'h0);
      check("rst_valid", {31'b0, valid}, 32'h0);
      check("rst_locked", {31'b0, locked}, 32'h0);
      check("rst_perr", {31'b0, parity_err}, 32'h0);
      rst_n = 1'b1;
      idle(80);

      // Basic B/W pair
      send_sub(PB, 28'h8ABCDE0, 28);
      send_sub(PW, 28'h8123450, 28);
      pulse(3);
      check("a_valid_cnt", valid_cnt, 1);
      check("a_left", data_left, 32'h8ABCDE01);
      check("a_right", data_right, 32'h81234504);
      check("a_locked", {31'b0, locked}, 32'h1);

      // Same stream with inverted line polarity
      idle(80);
      check("b_unlocked", {31'b0, locked}, 32'h0);
      spdif_in = 1'b1;
      idle(80);
      send_sub(PB, 28'h8ABCDE0, 28);
      send_sub(PW, 28'h8123450, 28);
      pulse(3);
      check("b_valid_cnt", valid_cnt, 2);
      check("b_left", data_left, 32'h8ABCDE01);
      check("b_right", data_right, 32'h81234504);
      check("b_locked", {31'b0, locked}, 32'h1);
      idle(80);

      // Line stalls in the middle of DATA
      send_sub(PB, 28'h1234567, 28);
      send_sub(PW, 28'hFFFFFFF, 28);
      send_sub(PB, 28'h1234567, 10);
      spdif_in = ~spdif_in;
      idle(50);
      check("c_valid_cnt", valid_cnt, 3);
      check("c_locked_before", {31'b0, locked}, 32'h1);
      idle(12);
      check("c_locked_after", {31'b0, locked}, 32'h0);
      check("c_left_hold", data_left, 32'h12345671);
      check("c_right_hold", data_right, 32'hFFFFFFF4);
      idle(80);
      check("c_no_valid", valid_cnt, 3);

      // Two W subframes in a row, then recovery
      send_sub(PM, 28'h0000003, 28);
      send_sub(PW, 28'h5A5A5A5, 28);
      send_sub(PW, 28'h5A5A5A5, 28);
      check("d_valid_cnt", valid_cnt, 4);
      check("d_left", data_left, 32'h00000032);
      check("d_right", data_right, 32'h5A5A5A54);
      check("d_locked", {31'b0, locked}, 32'h0);
      send_sub(PB, 28'h8ABCDE0, 28);
      send_sub(PW, 28'h8123450, 28);
      pulse(3);
      check("d_recover_cnt", valid_cnt, 5);
      check("d_recover_left", data_left, 32'h8ABCDE01);
      check("d_recover_right", data_right, 32'h81234504);
      check("d_recover_locked", {31'b0, locked}, 32'h1);
      idle(80);

      // Parity error on the right subframe (slot 31 flipped)
      v0 = valid_cnt;
      p0 = perr_cnt;
      send_sub(PB, 28'h8ABCDE0, 28);
      send_sub(PW, 28'h8123450, 28);
      send_sub(PM, 28'h0000003, 28);
      send_sub(PW, 28'h0123450, 28);
      pulse(3);
      check("e_locked", {31'b0, locked}, 32'h1);
`ifdef SPDIF_RX_PARITY_CHECK_EN
      check("e_valid_cnt", valid_cnt, v0 + 1);
      check("e_perr_cnt", perr_cnt, p0 + 1);
      check("e_right", data_right, 32'h81234504);
`else
      check("e_valid_cnt", valid_cnt, v0 + 2);
      check("e_perr_cnt", perr_cnt, p0);
      check("e_right", data_right, 32'h01234504);
      check("e_left", data_left, 32'h00000032);
`endif
      idle(80);

      // One-clock reset at slot 15 of a left subframe
      v0 = valid_cnt;
      send_sub(PB, 28'h1234567, 11);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      check("f_left", data_left, 32'h0);
      check("f_right", data_right, 32'h0);
      check("f_locked", {31'b0, locked}, 32'h0);
      check("f_valid", {31'b0, valid}, 32'h0);
      check("f_perr", {31'b0, parity_err}, 32'h0);
      idle(80);
      check("f_no_valid", valid_cnt, v0);
      send_sub(PB, 28'h1234567, 28);
      send_sub(PW, 28'hFFFFFFF, 28);
      pulse(3);
      check("f_valid_cnt", valid_cnt, v0 + 1);
      check("f_new_left", data_left, 32'h12345671);
      check("f_new_right", data_right, 32'hFFFFFFF4);
      check("f_new_locked", {31'b0, locked}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
